// File: rtl/btn_event.sv
// -----------------------------------------------------------------------------
// btn_event
// Turns a debounced button level into discrete user-interface events:
// press, release, long-press and (optionally) auto-repeat while long-held.
//
// Parameters
//   LONG_CYC    cycles btn_db must stay high after press_pulse before
//               long_pulse (2 .. 2^24-1)
//   REPEAT_CYC  cycles between successive repeat_pulse while held
//               (2 .. 2^24-1)
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   btn_db         in   debounced button level, synchronous to clk, 1 = pressed
//   press_pulse    out  one-cycle strobe on press
//   release_pulse  out  one-cycle strobe on release
//   long_pulse     out  one-cycle strobe when the press qualifies as long
//   repeat_pulse   out  one-cycle auto-repeat strobe while long-held
//   held           out  level, high while the FSM is in HELD
//   press_count    out  8-bit wrapping count of press events
//
// Configuration
//   BTN_EVENT_REPEAT_EN  defined: auto-repeat compiled in.
//                        undefined: repeat_pulse stays 0 and the counter is
//                        frozen in HELD; HELD is left only on release.
// -----------------------------------------------------------------------------
module btn_event #(
  parameter logic [23:0] LONG_CYC   = 24'd12_000_000,
  parameter logic [23:0] REPEAT_CYC = 24'd3_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_db,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

`ifdef BTN_EVENT_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam logic [23:0] LONG_LAST   = LONG_CYC - 24'd1;
  localparam logic [23:0] REPEAT_LAST = REPEAT_CYC - 24'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        btn_q;

  logic        press_d, release_d, long_d, repeat_d, held_d;
  logic        press_q, release_q, long_q, repeat_q, held_q;
  logic [7:0]  count_q, count_d;

  // Terminal counts, shared by next-state and output logic.
  logic long_hit, repeat_hit;
  assign long_hit   = (cnt_q == LONG_LAST);
  assign repeat_hit = REPEAT_EN && (cnt_q == REPEAT_LAST);

  // ---------------------------------------------------------------------------
  // State register (plus input register, counter and registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_db;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: acts on the registered button level only.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (btn_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        // Release wins over a coincident long terminal count.
        if (!btn_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (long_hit) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      HELD: begin
        if (!btn_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (REPEAT_EN) begin
          cnt_d = repeat_hit ? '0 : cnt_q + 24'd1;
        end
        // Without auto-repeat the counter simply holds its value.
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the output registers, so every strobe lands
  // on the same edge as the state change that causes it.
  // ---------------------------------------------------------------------------
  always_comb begin
    press_d   = (state_q == IDLE) && btn_q;
    release_d = ((state_q == PRESSED) || (state_q == HELD)) && !btn_q;
    long_d    = (state_q == PRESSED) && btn_q && long_hit;
    repeat_d  = (state_q == HELD) && btn_q && repeat_hit;
    held_d    = (state_d == HELD);
    // Count moves on the same edge press_pulse rises; wraps naturally.
    count_d   = press_d ? count_q + 8'd1 : count_q;
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_btn_event.sv
// -----------------------------------------------------------------------------
// tb_btn_event
// Directed bench for btn_event with LONG_CYC=8, REPEAT_CYC=4. Inputs change
// 1 ns after a rising edge; outputs are read 1 ns after the next rising edge.
// Edge numbers below count rising edges since btn_db was first driven high.
// -----------------------------------------------------------------------------
module tb_btn_event;

  logic       clk;
  logic       rst_n;
  logic       btn_db;
  logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic [7:0] press_count;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef BTN_EVENT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  btn_event #(
    .LONG_CYC   (24'd8),
    .REPEAT_CYC (24'd4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_db        (btn_db),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_count   (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {press, release, long, repeat, held, press_count}
  function automatic logic [12:0] outs();
    return {press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got p/r/l/rp/h=%b cnt=%0d, want p/r/l/rp/h=%b cnt=%0d",
               name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  // Drive btn_db, advance one rising edge, settle.
  task automatic tick(input logic b);
    btn_db = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_db = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       btn;
    logic [4:0] pulses;  // press, release, long, repeat, held
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0] cnt_exp;
    logic [4:0] p;

    // Short press (3 edges high) then a toggling input.
    vecs[0]  = '{1'b1, 5'b00000, 8'd0};
    vecs[1]  = '{1'b1, 5'b10000, 8'd1};  // press 2 edges after rise
    vecs[2]  = '{1'b1, 5'b00000, 8'd1};
    vecs[3]  = '{1'b0, 5'b00000, 8'd1};
    vecs[4]  = '{1'b0, 5'b01000, 8'd1};  // release, no long
    vecs[5]  = '{1'b0, 5'b00000, 8'd1};
    vecs[6]  = '{1'b1, 5'b00000, 8'd1};  // toggle every cycle
    vecs[7]  = '{1'b0, 5'b10000, 8'd2};
    vecs[8]  = '{1'b1, 5'b01000, 8'd2};
    vecs[9]  = '{1'b0, 5'b10000, 8'd3};
    vecs[10] = '{1'b0, 5'b01000, 8'd3};
    vecs[11] = '{1'b0, 5'b00000, 8'd3};

    btn_db = 1'b0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_async", outs(), 13'd0);
    @(posedge clk);
    #1 check("reset_held", outs(), 13'd0);
    rst_n = 1'b1;
    tick(1'b0);
    check("idle_after_reset", outs(), 13'd0);

    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].btn);
      check($sformatf("vec%0d", i), outs(), {vecs[i].pulses, vecs[i].cnt});
    end

    // Long hold: btn high for edges 1..20, low afterwards.
    // press @2, long @10, repeats @14,@18, release @22 (coincides with the
    // next repeat terminal count, which release must suppress).
    do_reset();
    for (int e = 1; e <= 26; e++) begin
      tick(e <= 20);
      cnt_exp = (e >= 2) ? 8'd1 : 8'd0;
      p = {e == 2, e == 22, e == 10, REP && (e == 14 || e == 18),
           e >= 10 && e <= 21};
      check($sformatf("long_hold_e%0d", e), outs(), {p, cnt_exp});
    end

    // Release lands exactly when cnt reaches LONG_CYC-1: btn high edges 1..8.
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      tick(e <= 8);
      cnt_exp = (e >= 2) ? 8'd1 : 8'd0;
      p = {e == 2, e == 10, 1'b0, 1'b0, 1'b0};
      check($sformatf("edge_release_e%0d", e), outs(), {p, cnt_exp});
    end

    // 256 short presses wrap the count to 0; the 257th gives 1.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    end
    check("wrap_256", outs(), {5'b00000, 8'd0});
    tick(1'b1); tick(1'b1);
    check("wrap_257", outs(), {5'b10000, 8'd1});
    tick(1'b0); tick(1'b0); tick(1'b0);

    // Reset during HELD with btn still high.
    do_reset();
    for (int e = 1; e <= 12; e++) tick(1'b1);
    check("pre_reset_held", {3'b000, held, 1'b0, press_count}, {3'b000, 1'b1, 1'b0, 8'd1});
    #2 rst_n = 1'b0;
    #1 check("mid_reset_async", outs(), 13'd0);
    @(posedge clk);
    #1 check("mid_reset_edge1", outs(), 13'd0);
    @(posedge clk);
    #1 check("mid_reset_edge2", outs(), 13'd0);
    rst_n = 1'b1;
    tick(1'b1);
    check("post_reset_e1", outs(), 13'd0);
    tick(1'b1);
    check("post_reset_e2", outs(), {5'b10000, 8'd1});
    tick(1'b1);
    check("post_reset_e3", outs(), {5'b00000, 8'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/btn_event.md
BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 Parameter LONG_CYC, default 24'd12_000_000, cycles btn_db must stay high after press_pulse before long_pulse; legal range 2..2^24-1.
REQ-002 Parameter REPEAT_CYC, default 24'd3_000_000, cycles between successive repeat_pulse while held; legal range 2..2^24-1.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_db  input  1  debounced button level from the debounce stage, synchronous to clk, high = pressed.
REQ-006 press_pulse  output  1  one-cycle strobe on press.
REQ-007 release_pulse  output  1  one-cycle strobe on release.
REQ-008 long_pulse  output  1  one-cycle strobe when a press qualifies as long.
REQ-009 repeat_pulse  output  1  one-cycle auto-repeat strobe while long-held.
REQ-010 held  output  1  level, high while in HELD state.
REQ-011 press_count  output  8  count of press_pulse events, wraps.

Function
REQ-012 btn_db SHALL be registered once into btn_q; the FSM SHALL act on btn_q only; all outputs SHALL be registered.
REQ-013 FSM states SHALL be IDLE, PRESSED, HELD; single 24-bit cycle counter cnt.
REQ-014 IDLE with btn_q=1 -> PRESSED, cnt<=0, press_pulse=1 next cycle; latency btn_db rise to press_pulse = 2 clock edges.
REQ-015 PRESSED with btn_q=1: cnt increments; when cnt==LONG_CYC-1 -> HELD, cnt<=0, long_pulse=1; long_pulse SHALL appear exactly LONG_CYC cycles after press_pulse.
REQ-016 HELD with btn_q=1: cnt increments; when cnt==REPEAT_CYC-1 -> cnt<=0, repeat_pulse=1, remain HELD; first repeat_pulse exactly REPEAT_CYC cycles after long_pulse.
REQ-017 PRESSED or HELD with btn_q=0 -> IDLE, release_pulse=1; release SHALL take priority over a long/repeat terminal count in the same cycle (no long_pulse/repeat_pulse issued).
REQ-018 Release in PRESSED (short press) SHALL produce press_pulse and release_pulse only, no long_pulse.
REQ-019 Each pulse output SHALL be high for exactly one cycle; at most one of press/release/long/repeat high in any cycle.
REQ-020 held SHALL be 1 in every cycle the FSM is in HELD, 0 otherwise, registered with same timing as long_pulse rise and release_pulse.
REQ-021 press_count SHALL increment by 1 in the cycle press_pulse is high; 255 -> 0 wrap, no saturation.
REQ-022 btn_db toggling every cycle SHALL produce alternating press_pulse/release_pulse with no lost or merged events.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, cnt=0, btn_q=0, all pulse outputs 0, held=0, press_count=0.
REQ-024 Reset asserted mid-press SHALL emit no release_pulse; after deassertion with btn_db still high, a fresh press_pulse SHALL follow 2 edges later.

Configuration
REQ-025 Macro BTN_EVENT_REPEAT_EN defined: auto-repeat per REQ-016 compiled in.
REQ-026 Macro BTN_EVENT_REPEAT_EN undefined: repeat_pulse tied 0, cnt frozen in HELD, HELD exits only on release; all other behaviour unchanged.

Verification (bench uses LONG_CYC=8, REPEAT_CYC=4, macro defined unless stated)
REQ-027 Press 3 cycles then release -> one press_pulse, one release_pulse, no long_pulse, press_count=1.
REQ-028 Hold 20 cycles -> long_pulse 8 cycles after press_pulse, repeat_pulse at +4, +8 after long_pulse, held=1 from long_pulse until release_pulse.
REQ-029 Release on exact cycle cnt reaches 7 in PRESSED -> release_pulse only, no long_pulse, held stays 0.
REQ-030 256 short presses -> press_count returns to 0; 257th gives 1.
REQ-031 rst_n pulsed low during HELD with btn_db high -> all outputs 0 during reset, no release_pulse, press_pulse 2 edges after rst_n rises.
REQ-032 Macro undefined, hold 20 cycles -> long_pulse once, repeat_pulse never asserted, release_pulse on release.
